// File: rtl/track_pkg.sv
// Shared encodings for the track sequencer and the sensor synchronizer side:
// controller states, route phases and the condition codes driven on Selector.
package track_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_GAP     = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_DONE    = 3'd6,
        ST_FAULT   = 3'd7
    } trackState_t;

    typedef enum logic [1:0] {
        PHASE_0 = 2'd0,
        PHASE_1 = 2'd1,
        PHASE_2 = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        COND_ENDS_OCCUPIED = 2'd0,
        COND_WEST_CLEAR    = 2'd1,
        COND_EAST_CLEAR    = 2'd2,
        COND_FORCED        = 2'd3
    } cond_t;

    localparam int TIMER_W    = 24;
    localparam int GAP_W      = 8;
    localparam int DEBOUNCE_W = 4;

    function automatic cond_t phaseCond(input phase_t p);
        case (p)
            PHASE_0: return COND_ENDS_OCCUPIED;
            PHASE_1: return COND_WEST_CLEAR;
            default: return COND_EAST_CLEAR;
        endcase
    endfunction

    // The last phase has no successor; it stays put.
    function automatic phase_t nextPhase(input phase_t p);
        return (p == PHASE_0) ? PHASE_1 : PHASE_2;
    endfunction

endpackage

// File: rtl/track_sequencer_poll_timer.sv
// Poll-gap down-counter and per-phase timeout up-counter for the track sequencer.
// gapExpire is high on the last GAP cycle; timeoutExpire flags the cycle whose increment reaches TIMEOUT-1.
module poll_timer
    import track_pkg::*;
#(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gapLoad,
    input  logic gapRun,
    input  logic timeoutClear,
    input  logic timeoutRun,
    output logic gapExpire,
    output logic timeoutExpire
);

    localparam logic [GAP_W-1:0]   GAP_RELOAD   = GAP_W'(POLL_GAP - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_TRIP = TIMER_W'(TIMEOUT - 2);

    logic [GAP_W-1:0]   gapCnt;
    logic [TIMER_W-1:0] timeoutCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gapCnt     <= '0;
            timeoutCnt <= '0;
        end else begin
            if (gapLoad)
                gapCnt <= GAP_RELOAD;
            else if (gapRun && gapCnt != '0)
                gapCnt <= gapCnt - 1'b1;

            // Saturates so a stalled phase can never wrap back into range.
            if (timeoutClear)
                timeoutCnt <= '0;
            else if (timeoutRun && timeoutCnt != TIMEOUT_LAST)
                timeoutCnt <= timeoutCnt + 1'b1;
        end
    end

    assign gapExpire     = (gapCnt == '0);
    assign timeoutExpire = timeoutRun && (timeoutCnt >= TIMEOUT_TRIP);

endmodule

// File: rtl/track_sequencer.sv
// Route controller: polls three track conditions in turn with debounce, throws the turnout, faults on timeout.
// Enable strobes one cycle per poll; the sensor side answers on Y two cycles later, no other handshake.
module track_sequencer
    import track_pkg::*;
#(
    parameter int POLL_GAP   = 4,
    parameter int DEBOUNCE_N = 3,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Y,
    output logic [1:0] Selector,
    output logic       Enable,
    output logic       Switch,
    output logic       Stop,
    output logic       Busy,
    output logic       Done,
    output logic       Fault
);

    localparam logic [DEBOUNCE_W-1:0] DEBOUNCE_MAX = DEBOUNCE_W'(DEBOUNCE_N);

    trackState_t            state, nextState;
    phase_t                 phase;
    logic [DEBOUNCE_W-1:0]  debounceCnt, debounceNext;
    logic                   gapLoad, gapExpire, timeoutClear, timeoutRun, timeoutExpire;
    logic                   runStart;

    assign timeoutRun = state inside {ST_REQ, ST_SETTLE, ST_SAMPLE, ST_GAP};

    poll_timer #(
        .POLL_GAP (POLL_GAP),
        .TIMEOUT  (TIMEOUT)
    ) u_pollTimer (
        .clk           (clk),
        .rst_n         (rst_n),
        .gapLoad       (gapLoad),
        .gapRun        (state == ST_GAP),
        .timeoutClear  (timeoutClear),
        .timeoutRun    (timeoutRun),
        .gapExpire     (gapExpire),
        .timeoutExpire (timeoutExpire)
    );

    always_comb begin
        nextState    = state;
        debounceNext = debounceCnt;
        gapLoad      = 1'b0;
        timeoutClear = 1'b0;
        runStart     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    nextState    = ST_REQ;
                    timeoutClear = 1'b1;
                    runStart     = 1'b1;
                    debounceNext = '0;
                end
            end
            ST_REQ:    nextState = ST_SETTLE;
            ST_SETTLE: nextState = ST_SAMPLE;
            ST_SAMPLE: begin
                if (Y)
                    debounceNext = (debounceCnt >= DEBOUNCE_MAX) ? DEBOUNCE_MAX : debounceCnt + 1'b1;
                else
                    debounceNext = '0;
                if (debounceNext == DEBOUNCE_MAX) begin
                    nextState = ST_ADVANCE;
                end else begin
                    nextState = ST_GAP;
                    gapLoad   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gapExpire)
                    nextState = ST_REQ;
            end
            ST_ADVANCE: begin
                timeoutClear = 1'b1;
                debounceNext = '0;
                nextState    = (phase == PHASE_2) ? ST_DONE : ST_REQ;
            end
            ST_DONE, ST_FAULT: begin
                if (Ack)
                    nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
        // A phase that runs out of time faults even if this very sample completed the debounce.
        if (timeoutExpire)
            nextState = ST_FAULT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            phase       <= PHASE_0;
            debounceCnt <= '0;
            Switch      <= 1'b0;
            Stop        <= 1'b1;
        end else begin
            state       <= nextState;
            debounceCnt <= debounceNext;

            if (nextState == ST_IDLE || runStart) begin
                phase <= PHASE_0;
            end else if (state == ST_ADVANCE && nextState == ST_REQ) begin
                phase  <= nextPhase(phase);
                Switch <= (phase == PHASE_0);
            end

            if (runStart)
                Stop <= 1'b0;
            else if (nextState == ST_FAULT)
                Stop <= 1'b1;
            else if (state == ST_FAULT)
                Stop <= 1'b0;
        end
    end

    // During ADVANCE the selector already shows the next phase, so the first REQ of a phase sees a settled code.
    assign Selector = (state == ST_ADVANCE) ? phaseCond(nextPhase(phase)) : phaseCond(phase);
    assign Enable   = (state == ST_REQ);
    assign Busy     = state inside {ST_REQ, ST_SETTLE, ST_SAMPLE, ST_GAP, ST_ADVANCE};
    assign Done     = (state == ST_DONE);
    assign Fault    = (state == ST_FAULT);

endmodule
